// File: rtl/addr_pkg.sv
// Shared definitions for the segment:offset address sequencer.
package addr_pkg;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CALC  = 2'd2;
    localparam logic [1:0] ST_ISSUE = 2'd3;

    // Idle OP value; also forces an OP change on every transaction
    localparam logic [2:0] OP_PARK = 3'h7;

    // Addressing modes understood by the ALU
    localparam logic [2:0] MODE_IP          = 3'd0;
    localparam logic [2:0] MODE_REL         = 3'd1;
    localparam logic [2:0] MODE_REG         = 3'd2;
    localparam logic [2:0] MODE_REG_REL     = 3'd3;
    localparam logic [2:0] MODE_REG_REG     = 3'd4;
    localparam logic [2:0] MODE_REG_REG_REL = 3'd5;

    // Operand set presented to the ALU
    typedef struct packed {
        logic [15:0] seg;
        logic [15:0] ip;
        logic [15:0] rel;
        logic [15:0] reg1;
        logic [15:0] reg2;
    } alu_opnd_t;

    // Modes above the last defined one would collide with PARK, so fold them to REG
    function automatic logic [2:0] legal_mode(input logic [2:0] m);
        return (m > MODE_REG_REG_REL) ? MODE_REG : m;
    endfunction

endpackage

// File: rtl/addr_arb_pick.sv
// Winner select between fetch and EU with an EU burst limit.
module addr_arb_pick
    import addr_pkg::*;
#(
    parameter int MAX_EU_BURST = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_req_i,
    input  logic eu_req_i,
    input  logic grant_i,
    output logic pick_any_o,
    output logic pick_fetch_o
);

    localparam int BW = (MAX_EU_BURST < 1) ? 1 : $clog2(MAX_EU_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_EU_BURST);

    logic [BW-1:0] burst_q, burst_d;
    logic          burst_full;

    assign burst_full   = (burst_q == BURST_MAX);
    assign pick_any_o   = fetch_req_i | eu_req_i;
    // EU wins unless fetch has waited through a full EU burst
    assign pick_fetch_o = fetch_req_i & (~eu_req_i | burst_full);

    // Count EU grants that starved a pending fetch; anything else restarts the burst
    always_comb begin
        burst_d = burst_q;
        if (grant_i) begin
            if (pick_fetch_o || !fetch_req_i)
                burst_d = '0;
            else
                burst_d = burst_q + 1'b1;
        end
    end

    // Burst counter register
    always_ff @(posedge clk) begin
        if (!rst_n)
            burst_q <= '0;
        else
            burst_q <= burst_d;
    end

endmodule

// File: rtl/addr_bus_ctrl.sv
// Arbitrates fetch/EU address requests, sequences the external address
// ALU and runs one valid/ready bus cycle with a timeout per request.
module addr_bus_ctrl
    import addr_pkg::*;
#(
    parameter int MAX_EU_BURST = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic [15:0] fetch_cs,
    input  logic [15:0] fetch_ip,
    output logic        fetch_gnt,
    output logic        fetch_done,
    input  logic        eu_req,
    input  logic [2:0]  eu_mode,
    input  logic        eu_write,
    input  logic [15:0] eu_seg,
    input  logic [15:0] eu_relative,
    input  logic [15:0] eu_reg1,
    input  logic [15:0] eu_reg2,
    output logic        eu_gnt,
    output logic        eu_done,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_segment,
    output logic [15:0] alu_ip,
    output logic [15:0] alu_relative,
    output logic [15:0] alu_reg1,
    output logic [15:0] alu_reg2,
    input  logic [19:0] alu_direction,
    output logic [19:0] bus_addr,
    output logic        bus_valid,
    output logic        bus_write,
    input  logic        bus_ready,
    output logic        bus_err,
    output logic        busy
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    alu_opnd_t     opnd_q, opnd_new;
    logic [2:0]    mode_q, mode_new;
    logic          wr_q, wr_new;
    logic          win_fetch_q;
    logic [2:0]    alu_op_q;
    logic          fetch_gnt_q, eu_gnt_q, fetch_done_q, eu_done_q, bus_err_q;
    logic [19:0]   bus_addr_q;
    logic          bus_valid_q, bus_write_q;
    logic          pick_any, pick_fetch;
    logic          latch, finish, abort;

    addr_arb_pick #(.MAX_EU_BURST(MAX_EU_BURST)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_req_i  (fetch_req),
        .eu_req_i     (eu_req),
        .grant_i      (latch),
        .pick_any_o   (pick_any),
        .pick_fetch_o (pick_fetch)
    );

    // Operand set, mode and direction of whichever requester wins this cycle
    always_comb begin
        opnd_new = '0;
        if (pick_fetch) begin
            opnd_new.seg = fetch_cs;
            opnd_new.ip  = fetch_ip;
            mode_new     = MODE_IP;
            wr_new       = 1'b0;
        end else begin
            opnd_new.seg  = eu_seg;
            opnd_new.rel  = eu_relative;
            opnd_new.reg1 = eu_reg1;
            opnd_new.reg2 = eu_reg2;
            mode_new      = legal_mode(eu_mode);
            wr_new        = eu_write;
        end
    end

    // Sequencer next state plus the bus timeout count
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        latch   = 1'b0;
        finish  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    latch   = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_CALC;
            ST_CALC: begin
                tmo_d   = '0;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A ready on the last allowed cycle still completes cleanly
                if (bus_ready) begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    finish  = 1'b1;
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, ALU operand/OP registers, bus cycle registers and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            opnd_q       <= '0;
            mode_q       <= '0;
            wr_q         <= 1'b0;
            win_fetch_q  <= 1'b0;
            alu_op_q     <= OP_PARK;
            fetch_gnt_q  <= 1'b0;
            eu_gnt_q     <= 1'b0;
            fetch_done_q <= 1'b0;
            eu_done_q    <= 1'b0;
            bus_err_q    <= 1'b0;
            bus_addr_q   <= '0;
            bus_valid_q  <= 1'b0;
            bus_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            fetch_gnt_q  <= latch & pick_fetch;
            eu_gnt_q     <= latch & ~pick_fetch;
            fetch_done_q <= finish & win_fetch_q;
            eu_done_q    <= finish & ~win_fetch_q;
            bus_err_q    <= abort;
            if (latch) begin
                opnd_q      <= opnd_new;
                mode_q      <= mode_new;
                wr_q        <= wr_new;
                win_fetch_q <= pick_fetch;
            end
            // OP leaves PARK only once operands have settled, and returns after the bus cycle
            if (state_q == ST_LOAD)
                alu_op_q <= mode_q;
            else if (finish)
                alu_op_q <= OP_PARK;
            // Capture the ALU result once; it stays frozen for the whole bus cycle
            if (state_q == ST_CALC) begin
                bus_addr_q  <= alu_direction;
                bus_write_q <= wr_q;
                bus_valid_q <= 1'b1;
            end else if (finish) begin
                bus_valid_q <= 1'b0;
            end
        end
    end

    assign fetch_gnt    = fetch_gnt_q;
    assign eu_gnt       = eu_gnt_q;
    assign fetch_done   = fetch_done_q;
    assign eu_done      = eu_done_q;
    assign bus_err      = bus_err_q;
    assign alu_op       = alu_op_q;
    assign alu_segment  = opnd_q.seg;
    assign alu_ip       = opnd_q.ip;
    assign alu_relative = opnd_q.rel;
    assign alu_reg1     = opnd_q.reg1;
    assign alu_reg2     = opnd_q.reg2;
    assign bus_addr     = bus_addr_q;
    assign bus_valid    = bus_valid_q;
    assign bus_write    = bus_write_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
